// File: rtl/bus_pkg.sv
// Shared types, owner encodings, default address map and the address decode
// helper for the AHB-Lite interconnect.
package bus_pkg;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    localparam int MAX_SLV = 16;
    localparam int MAX_W   = 64;
    localparam int DSEL_W  = 5;

    // Slave indices occupy 0..15, so the two special owners sit above them.
    localparam logic [DSEL_W-1:0] DSEL_DEFAULT = 5'd16;
    localparam logic [DSEL_W-1:0] DSEL_NONE    = 5'd17;

    localparam logic [127:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] DEF_SLV_MASK = {4{32'hF000_0000}};

    typedef logic [MAX_SLV-1:0][MAX_W-1:0] map_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } dec_t;

    // Walks from the top slot down so the lowest matching slot wins.
    function automatic dec_t bus_decode(input logic [MAX_W-1:0]   addr,
                                        input map_t               base,
                                        input map_t               mask,
                                        input logic [MAX_SLV-1:0] en);
        dec_t r;
        r = '0;
        for (int k = MAX_SLV - 1; k >= 0; k--) begin
            if (en[k] && ((addr & mask[k]) == base[k])) begin
                r.hit = 1'b1;
                r.idx = 4'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_default_slave.sv
// Default slave for unmapped or timed-out accesses: two-cycle ERROR response
// FSM plus the saturating count of completed ERROR responses on the bus.
module bus_default_slave
    import bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        bus_ready_i,
    input  logic        bus_resp_i,
    output logic        ready_o,
    output logic        resp_o,
    output logic [15:0] errcnt_o
);

    ds_state_e state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= DS_IDLE;
            ready_o <= 1'b1;
            resp_o  <= 1'b0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (start_i) begin
                        state   <= DS_ERR1;
                        ready_o <= 1'b0;
                        resp_o  <= 1'b1;
                    end
                end
                DS_ERR1: begin
                    state   <= DS_ERR2;
                    ready_o <= 1'b1;
                    resp_o  <= 1'b1;
                end
                DS_ERR2: begin
                    if (start_i) begin
                        state   <= DS_ERR1;
                        ready_o <= 1'b0;
                        resp_o  <= 1'b1;
                    end else begin
                        state   <= DS_IDLE;
                        ready_o <= 1'b1;
                        resp_o  <= 1'b0;
                    end
                end
                default: begin
                    state   <= DS_IDLE;
                    ready_o <= 1'b1;
                    resp_o  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            errcnt_o <= '0;
        end else if (bus_ready_i && bus_resp_i && (errcnt_o != 16'hFFFF)) begin
            errcnt_o <= errcnt_o + 16'd1;
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, registered data-phase
// owner, response mux and default ERROR slave. Define BUS_TIMEOUT_EN to build
// the hung-slave watchdog; otherwise timeout_o is tied low.
module ahb_lite_interconnect
    import bus_pkg::*;
#(
    parameter int                           DWidth        = 32,
    parameter int                           NumofSlave    = 4,
    parameter logic [NumofSlave*DWidth-1:0] SlvBase       = DEF_SLV_BASE,
    parameter logic [NumofSlave*DWidth-1:0] SlvMask       = DEF_SLV_MASK,
    parameter int                           TimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DWidth-1:0]            addr_i,
    input  logic                         trans_i,
    input  logic [NumofSlave*DWidth-1:0] rdata_i,
    input  logic [NumofSlave-1:0]        resp_i,
    input  logic [NumofSlave-1:0]        readyout_i,
    output logic [NumofSlave-1:0]        sel_o,
    output logic [DWidth-1:0]            rdata_o,
    output logic                         resp_o,
    output logic                         ready_o,
    output logic                         timeout_o,
    output logic [15:0]                  errcnt_o
);

    map_t               base_ext;
    map_t               mask_ext;
    logic [MAX_SLV-1:0] slot_en;
    dec_t               dec;
    logic [DSEL_W-1:0]  dsel_q;
    logic               ds_start;
    logic               ds_ready;
    logic               ds_resp;
    logic               wd_fire;

    always_comb begin
        base_ext = '0;
        mask_ext = '0;
        slot_en  = '0;
        for (int k = 0; k < NumofSlave; k++) begin
            base_ext[k] = MAX_W'(SlvBase[k*DWidth +: DWidth]);
            mask_ext[k] = MAX_W'(SlvMask[k*DWidth +: DWidth]);
            slot_en[k]  = 1'b1;
        end
        dec = bus_decode(MAX_W'(addr_i), base_ext, mask_ext, slot_en);
    end

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < NumofSlave; k++) begin
            sel_o[k] = trans_i && dec.hit && (dec.idx == 4'(k));
        end
    end

    always_comb begin
        ready_o = 1'b1;
        resp_o  = 1'b0;
        rdata_o = '0;
        if (dsel_q == DSEL_DEFAULT) begin
            ready_o = ds_ready;
            resp_o  = ds_resp;
        end else begin
            for (int k = 0; k < NumofSlave; k++) begin
                if (dsel_q == DSEL_W'(k)) begin
                    ready_o = readyout_i[k];
                    resp_o  = resp_i[k];
                    rdata_o = rdata_i[k*DWidth +: DWidth];
                end
            end
        end
    end

    // A watchdog expiry steals the data phase from the hung slave.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dsel_q <= DSEL_NONE;
        end else if (wd_fire) begin
            dsel_q <= DSEL_DEFAULT;
        end else if (ready_o) begin
            if (!trans_i) begin
                dsel_q <= DSEL_NONE;
            end else if (dec.hit) begin
                dsel_q <= {1'b0, dec.idx};
            end else begin
                dsel_q <= DSEL_DEFAULT;
            end
        end
    end

    assign ds_start = (trans_i && ready_o && !dec.hit) || wd_fire;

`ifdef BUS_TIMEOUT_EN
    localparam int WdRaw = $clog2(TimeoutCycles + 1);
    localparam int WdW   = (WdRaw < 8) ? 8 : ((WdRaw > 16) ? 16 : WdRaw);

    logic [WdW-1:0] wd_cnt;
    logic           owner_mapped;
    logic           timeout_q;

    assign owner_mapped = (dsel_q < DSEL_W'(NumofSlave));
    assign wd_fire      = owner_mapped && !ready_o &&
                          (wd_cnt == WdW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (ready_o || wd_fire) begin
                wd_cnt <= '0;
            end else if (owner_mapped) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    bus_default_slave u_default_slave (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (ds_start),
        .bus_ready_i (ready_o),
        .bus_resp_i  (resp_o),
        .ready_o     (ds_ready),
        .resp_o      (ds_resp),
        .errcnt_o    (errcnt_o)
    );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect with a cycle-level reference model
// of the bus rules and hand-computed expectations for key transfers.
module tb_ahb_lite_interconnect;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              trans;
    logic [DW-1:0]     addr;
    logic [NS*DW-1:0]  rdata_i;
    logic [NS-1:0]     resp_i;
    logic [NS-1:0]     readyout_i;
    logic [NS-1:0]     sel;
    logic [DW-1:0]     rdata;
    logic              resp;
    logic              ready;
    logic              timeout;
    logic [15:0]       errcnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner -1 = none, -2 = default slave, k = slave k.
    int m_owner  = -1;
    int m_phase  = 0;
    int m_stall  = 0;
    int m_errcnt = 0;
    bit m_to     = 1'b0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ahb_lite_interconnect #(
        .DWidth        (DW),
        .NumofSlave    (NS),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_i     (addr),
        .trans_i    (trans),
        .rdata_i    (rdata_i),
        .resp_i     (resp_i),
        .readyout_i (readyout_i),
        .sel_o      (sel),
        .rdata_o    (rdata),
        .resp_o     (resp),
        .ready_o    (ready),
        .timeout_o  (timeout),
        .errcnt_o   (errcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic [31:0] a);
        @(posedge clk);
        #1;
        trans = t;
        addr  = a;
    endtask

    always @(negedge clk) begin
        int         hit_k;
        logic       e_rdy;
        logic       e_rsp;
        logic [31:0] e_rd;
        logic [NS-1:0] e_sel;
        bit         fire;
        if (chk_en) begin
            hit_k = -1;
            for (int k = 0; k < NS; k++) begin
                if (hit_k < 0 && ((addr & 32'hF000_0000) == (32'(k) << 28))) hit_k = k;
            end
            e_sel = '0;
            if (trans && hit_k >= 0) e_sel[hit_k] = 1'b1;
            if (m_owner == -1) begin
                e_rdy = 1'b1; e_rsp = 1'b0; e_rd = '0;
            end else if (m_owner == -2) begin
                e_rdy = (m_phase == 2); e_rsp = 1'b1; e_rd = '0;
            end else begin
                e_rdy = readyout_i[m_owner];
                e_rsp = resp_i[m_owner];
                e_rd  = rdata_i[m_owner*DW +: DW];
            end
            chk("m_sel",     32'(sel),     32'(e_sel));
            chk("m_ready",   32'(ready),   32'(e_rdy));
            chk("m_resp",    32'(resp),    32'(e_rsp));
            chk("m_rdata",   rdata,        e_rd);
            chk("m_timeout", 32'(timeout), 32'(m_to));
            chk("m_errcnt",  32'(errcnt),  32'(m_errcnt));

            fire = 1'b0;
            if (rst) begin
                m_owner = -1; m_phase = 0; m_stall = 0; m_errcnt = 0; m_to = 1'b0;
            end else begin
                if (e_rdy && e_rsp && m_errcnt < 65535) m_errcnt++;
`ifdef BUS_TIMEOUT_EN
                if (m_owner >= 0 && !e_rdy) begin
                    m_stall++;
                    if (m_stall == TO) fire = 1'b1;
                end
`endif
                m_to = fire;
                if (fire) begin
                    m_owner = -2; m_phase = 1; m_stall = 0;
                end else if (e_rdy) begin
                    m_stall = 0;
                    if (!trans) m_owner = -1;
                    else if (hit_k >= 0) m_owner = hit_k;
                    else begin m_owner = -2; m_phase = 1; end
                end else if (m_owner == -2) begin
                    m_phase = 2;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; trans = 1'b0; addr = '0;
        resp_i = '0; readyout_i = '1;
        for (int k = 0; k < NS; k++) rdata_i[k*DW +: DW] = 32'hA000_0000 + 32'(k);

        @(posedge clk); #1; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready",   32'(ready),   32'h1);
        chk("rst_resp",    32'(resp),    32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_errcnt",  32'(errcnt),  32'h0);

        drive(1'b0, 32'h0); rst = 1'b0;
        @(negedge clk);
        chk("idle_sel",   32'(sel),   32'h0);
        chk("idle_ready", 32'(ready), 32'h1);

        rdata_i[1*DW +: DW] = 32'hDEAD_BEEF;
        drive(1'b1, 32'h1000_0010);
        @(negedge clk); chk("rd1_sel", 32'(sel), 32'h2);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("rd1_data",  rdata,       32'hDEAD_BEEF);
        chk("rd1_ready", 32'(ready),  32'h1);

        rdata_i[0*DW +: DW] = 32'h1111_0000;
        rdata_i[2*DW +: DW] = 32'h2222_0002;
        drive(1'b1, 32'h0000_0000);
        drive(1'b1, 32'h2000_0000); readyout_i[2] = 1'b0;
        @(negedge clk); chk("b2b_d0", rdata, 32'h1111_0000);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("b2b_w1", 32'(ready), 32'h0);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("b2b_w2", 32'(ready), 32'h0);
        drive(1'b0, 32'h0); readyout_i[2] = 1'b1;
        @(negedge clk);
        chk("b2b_ready", 32'(ready), 32'h1);
        chk("b2b_d2",    rdata,      32'h2222_0002);

        drive(1'b1, 32'h5000_0000);
        @(negedge clk); chk("um_sel", 32'(sel), 32'h0);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("um_e1_ready", 32'(ready), 32'h0);
        chk("um_e1_resp",  32'(resp),  32'h1);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("um_e2_ready", 32'(ready), 32'h1);
        chk("um_e2_resp",  32'(resp),  32'h1);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("um_errcnt", 32'(errcnt), 32'h1);

        drive(1'b1, 32'h7000_0000);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h9000_0004);
        @(negedge clk); chk("um2_e2_ready", 32'(ready), 32'h1);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("um2_re1_ready", 32'(ready), 32'h0);
        chk("um2_re1_resp",  32'(resp),  32'h1);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("um2_errcnt", 32'(errcnt), 32'h3);

        drive(1'b1, 32'h1000_0000);
        drive(1'b0, 32'h0); readyout_i[1] = 1'b0; resp_i[1] = 1'b1;
        drive(1'b0, 32'h0); readyout_i[1] = 1'b1;
        @(negedge clk); chk("serr_resp", 32'(resp), 32'h1);
        drive(1'b0, 32'h0); resp_i[1] = 1'b0;
        @(negedge clk); chk("serr_errcnt", 32'(errcnt), 32'h4);

        drive(1'b1, 32'h0000_0040); readyout_i[0] = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            drive(1'b0, 32'h0);
            @(negedge clk); chk("to_stall_timeout", 32'(timeout), 32'h0);
        end
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_e1_ready", 32'(ready), 32'h0);
        readyout_i[0] = 1'b1;
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("to_e2_resp",  32'(resp),    32'h1);
        chk("to_e2_pulse", 32'(timeout), 32'h0);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("to_errcnt", 32'(errcnt), 32'h5);
`else
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0);
            @(negedge clk); chk("hang_ready", 32'(ready), 32'h0);
        end
        drive(1'b0, 32'h0); readyout_i[0] = 1'b1;
        @(negedge clk); chk("hang_release", 32'(ready), 32'h1);
        drive(1'b0, 32'h0);
        @(negedge clk); chk("hang_errcnt", 32'(errcnt), 32'h4);
`endif

        rdata_i[3*DW +: DW] = 32'h3333_0003;
        drive(1'b1, 32'h3000_0000); readyout_i[3] = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk); chk("r3_wait", 32'(ready), 32'h0);
        drive(1'b0, 32'h0); rst = 1'b1;
        drive(1'b0, 32'h0); rst = 1'b0;
        @(negedge clk);
        chk("rst3_ready",  32'(ready),  32'h1);
        chk("rst3_resp",   32'(resp),   32'h0);
        chk("rst3_errcnt", 32'(errcnt), 32'h0);
        readyout_i[3] = 1'b1;
        drive(1'b1, 32'h3000_0004);
        @(negedge clk); chk("r3_sel", 32'(sel), 32'h8);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("r3_data",  rdata,      32'h3333_0003);
        chk("r3_ready", 32'(ready), 32'h1);
        drive(1'b0, 32'h0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_interconnect.md
# ahb_lite_interconnect

Parametrised AHB-Lite single-master interconnect between the CPU data port and `NumofSlave` memory-mapped slaves (external memory, NPU, future accelerators). It decodes the address phase against a per-slave base/mask map and registers the data-phase owner. It muxes slave responses back to the master and answers unmapped accesses from an internal default slave with a two-cycle ERROR response. It is the next-generation bus for the SoC top, with a configurable slave count, a configurable address map, error signalling and an optional hung-slave watchdog.

## Interface
- `DWidth`, 32, address/data width
- `NumofSlave`, 4, number of mapped slaves (1..16)
- `SlvBase`, {k<<28 per slave}, packed `NumofSlave*DWidth` base addresses; slot k is bits [k*DWidth +: DWidth]
- `SlvMask`, {32'hF000_0000 per slave}, packed `NumofSlave*DWidth` decode masks
- `TimeoutCycles`, 255, watchdog limit in cycles; used only with `BUS_TIMEOUT_EN`
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `addr_i`  in  DWidth  master address (address phase)
- `trans_i`  in  1  master transfer request
- `rdata_i`  in  NumofSlave*DWidth  slave read data, packed
- `resp_i`  in  NumofSlave  slave error response (1 = ERROR)
- `readyout_i`  in  NumofSlave  slave ready
- `sel_o`  out  NumofSlave  one-hot slave select (address phase)
- `rdata_o`  out  DWidth  read data to master
- `resp_o`  out  1  response to master
- `ready_o`  out  1  ready to master; also broadcast to slaves as bus ready
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires
- `errcnt_o`  out  16  saturating count of completed ERROR responses

## Operation
- Decode: slave k matches when `(addr_i & SlvMask[k]) == SlvBase[k]`. Multiple matches resolve to the lowest k. `sel_o` is combinational: one-hot on a match with `trans_i`=1, all zero otherwise.
- Address phase is accepted when `trans_i && ready_o`. The data-phase owner register `dsel_q` then loads: matched slave index, DEFAULT if no match, or NONE if `trans_i`=0. It updates only when `ready_o`=1.
- Data-phase mux:
  - owner k: `ready_o=readyout_i[k]`, `resp_o=resp_i[k]`, `rdata_o=rdata_i[k]`.
  - owner NONE: `ready_o=1`, `resp_o=0`, `rdata_o=0`.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 on an unmapped address-phase accept.
  - DS_ERR1 drives `ready_o=0`, `resp_o=1`, `rdata_o=0`, then goes to DS_ERR2.
  - DS_ERR2 drives `ready_o=1`, `resp_o=1`, then goes to DS_IDLE. If a new unmapped accept occurs in DS_ERR2, it goes to DS_ERR1 instead.
- `errcnt_o` increments on every cycle with `ready_o=1 && resp_o=1`, saturating at 16'hFFFF.

## Timing
- Reset values: `dsel_q`=NONE, FSM=DS_IDLE, `ready_o`=1, `resp_o`=0, `rdata_o`=0, `timeout_o`=0, `errcnt_o`=0, watchdog counter=0.
- Decode latency is 0 cycles (`sel_o`). Response-path latency is 0 cycles from the slave, via registered `dsel_q`.
- Pipelined: a new address phase may be accepted in the same cycle a data phase completes.
- Back-to-back mapped transfers to zero-wait slaves sustain 1 transfer per cycle.
- An ERROR to the master always takes exactly 2 cycles: ready low then ready high, both with `resp_o`=1.
- Reset asserted mid-transfer abandons the data phase. The next cycle shows the reset values, and `errcnt_o` is not incremented.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8..16-bit counter counts consecutive cycles in which a mapped slave owns the data phase with `readyout_i`=0.
  - When the count reaches `TimeoutCycles`: `timeout_o` pulses for 1 cycle, ownership moves to DEFAULT, and the FSM enters DS_ERR1, so the master receives the 2-cycle ERROR.
  - The counter clears on any `ready_o`=1 cycle.
- `BUS_TIMEOUT_EN` undefined: no counter is built, `timeout_o` is tied 0, and the bus waits indefinitely.

## Structure
- `bus_pkg` holds:
  - enum `ds_state_e`
  - `DSEL_NONE`/`DSEL_DEFAULT` encodings
  - default map constants
  - function `bus_decode(addr, base, mask)` returning the index plus a hit flag
- Sub-module `bus_default_slave`: the ERROR FSM and the `errcnt_o` saturating counter.

## Test plan
- Reset, then idle with `trans_i`=0 → `ready_o`=1, `resp_o`=0, `rdata_o`=0, `sel_o`=0.
- Read 0x1000_0010 with slave1 `rdata`=32'hDEAD_BEEF and zero wait → `sel_o`=4'b0010; next cycle `rdata_o`=32'hDEAD_BEEF, `ready_o`=1.
- Back-to-back reads to 0x0000_0000 then 0x2000_0000, slave2 inserting 2 wait states → `ready_o` low for 2 cycles; the second read data is taken from slave2 only.
- Access to 0x5000_0000 (unmapped) → `sel_o`=0, then `ready_o`=0/`resp_o`=1, then `ready_o`=1/`resp_o`=1; `errcnt_o`=1.
- With `BUS_TIMEOUT_EN` and `TimeoutCycles`=8, slave0 holds ready low → `timeout_o` pulses after 8 stalled cycles, a 2-cycle ERROR follows, and `errcnt_o` increments.
- Reset asserted while slave3 is in a wait state → next cycle `ready_o`=1 and `dsel_q`=NONE; the following transfer completes normally.
